// File: rtl/dbg_mem_loader.sv
// Debug-side burst loader driving the RV32I debug instruction/data cache ports.
// Define DBG_MEM_LOADER_VERIFY_EN to add a readback-and-compare after every write strobe.
module dbg_mem_loader #(
    parameter int READ_LAT = 1,
    parameter int LEN_W    = 8
) (
    input  logic             CPU_CLK,
    input  logic             CPU_RST,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic             cmd_target,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [3:0]       cmd_be,
    input  logic             wd_valid,
    output logic             wd_ready,
    input  logic [31:0]      wd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_last,
    output logic             rsp_err,
    output logic             busy,
    output logic [31:0]      dbg_inst_a2,
    output logic [31:0]      dbg_inst_wd2,
    output logic [3:0]       dbg_inst_we2,
    input  logic [31:0]      dbg_inst_rd2,
    output logic [31:0]      dbg_data_a2,
    output logic [31:0]      dbg_data_wd2,
    output logic [3:0]       dbg_data_we2,
    input  logic [31:0]      dbg_data_rd2
);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WRITE        = 3'd1,
        WSTROBE_LAST = 3'd2,
        RD_ADDR      = 3'd3,
        RD_WAIT      = 3'd4,
        RSP          = 3'd5,
        WSTROBE_V    = 3'd6,
        V_WAIT       = 3'd7
    } state_t;

    localparam logic [2:0] WAIT_INIT = 3'(READ_LAT - 1);

    state_t           state_q;
    logic [31:0]      addr_q;
    logic [LEN_W-1:0] cnt_q;
    logic             tgt_q;
    logic [3:0]       be_q;
    logic [2:0]       wait_q;
    logic [31:0]      inst_a2_q, inst_wd2_q, data_a2_q, data_wd2_q;
    logic [3:0]       inst_we2_q, data_we2_q;
    logic             rsp_valid_q, rsp_last_q;
    logic [31:0]      rsp_data_q;

    logic [31:0]      addr_d;
    logic [31:0]      cmd_word_addr_s;
    logic             last_beat_s;
    logic             addr_lsb_unused;

    assign addr_d          = addr_q + 32'd4;
    assign cmd_word_addr_s = {cmd_addr[31:2], 2'b00};
    assign last_beat_s     = (cnt_q == {LEN_W{1'b0}});
    assign addr_lsb_unused = ^cmd_addr[1:0];

`ifdef DBG_MEM_LOADER_VERIFY_EN
    logic last_q, err_q, rsp_err_q;
    logic mism_s;

    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        logic [31:0] m;
        m = 32'h0;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{be[b]}};
        end
        return m;
    endfunction

    function automatic logic verify_mismatch(input logic [31:0] rd, input logic [31:0] wd,
                                             input logic [3:0] be);
        return (((rd ^ wd) & be_to_mask(be)) != 32'h0);
    endfunction

    assign mism_s  = tgt_q ? verify_mismatch(dbg_data_rd2, data_wd2_q, be_q)
                           : verify_mismatch(dbg_inst_rd2, inst_wd2_q, be_q);
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign cmd_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign wd_ready     = (state_q == WRITE);
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_last     = rsp_last_q;
    assign dbg_inst_a2  = inst_a2_q;
    assign dbg_inst_wd2 = inst_wd2_q;
    assign dbg_inst_we2 = inst_we2_q;
    assign dbg_data_a2  = data_a2_q;
    assign dbg_data_wd2 = data_wd2_q;
    assign dbg_data_we2 = data_we2_q;

    // Burst FSM; write strobes last exactly one cycle since we2 defaults back to 0 every clock.
    always_ff @(posedge CPU_CLK or negedge CPU_RST) begin
        if (!CPU_RST) begin
            state_q     <= IDLE;
            addr_q      <= 32'h0;
            cnt_q       <= {LEN_W{1'b0}};
            tgt_q       <= 1'b0;
            be_q        <= 4'h0;
            wait_q      <= 3'd0;
            inst_a2_q   <= 32'h0;
            inst_wd2_q  <= 32'h0;
            inst_we2_q  <= 4'h0;
            data_a2_q   <= 32'h0;
            data_wd2_q  <= 32'h0;
            data_we2_q  <= 4'h0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'h0;
            rsp_last_q  <= 1'b0;
`ifdef DBG_MEM_LOADER_VERIFY_EN
            last_q      <= 1'b0;
            err_q       <= 1'b0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            inst_we2_q <= 4'h0;
            data_we2_q <= 4'h0;
            case (state_q)
                IDLE: begin
`ifdef DBG_MEM_LOADER_VERIFY_EN
                    err_q <= 1'b0;
`endif
                    if (cmd_valid) begin
                        addr_q <= cmd_word_addr_s;
                        cnt_q  <= cmd_len;
                        tgt_q  <= cmd_target;
                        be_q   <= cmd_target ? cmd_be : 4'hF;
                        // Unselected target is parked at zero for the whole burst.
                        if (cmd_target) begin
                            inst_a2_q  <= 32'h0;
                            inst_wd2_q <= 32'h0;
                            data_a2_q  <= cmd_word_addr_s;
                        end else begin
                            data_a2_q  <= 32'h0;
                            data_wd2_q <= 32'h0;
                            inst_a2_q  <= cmd_word_addr_s;
                        end
                        state_q <= cmd_write ? WRITE : RD_ADDR;
                    end
                end
                WRITE: begin
                    if (wd_valid) begin
                        if (tgt_q) begin
                            data_a2_q  <= addr_q;
                            data_wd2_q <= wd_data;
                            data_we2_q <= be_q;
                        end else begin
                            inst_a2_q  <= addr_q;
                            inst_wd2_q <= wd_data;
                            inst_we2_q <= be_q;
                        end
                        addr_q <= addr_d;
                        cnt_q  <= cnt_q - LEN_W'(1);
`ifdef DBG_MEM_LOADER_VERIFY_EN
                        last_q  <= last_beat_s;
                        state_q <= WSTROBE_V;
`else
                        state_q <= last_beat_s ? WSTROBE_LAST : WRITE;
`endif
                    end
                end
                WSTROBE_LAST: begin
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= 32'h0;
                    rsp_last_q  <= 1'b1;
                    state_q     <= RSP;
                end
`ifdef DBG_MEM_LOADER_VERIFY_EN
                WSTROBE_V: begin
                    wait_q  <= WAIT_INIT;
                    state_q <= V_WAIT;
                end
                V_WAIT: begin
                    if (wait_q == 3'd0) begin
                        if (last_q) begin
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= 32'h0;
                            rsp_last_q  <= 1'b1;
                            rsp_err_q   <= err_q | mism_s;
                            state_q     <= RSP;
                        end else begin
                            err_q   <= err_q | mism_s;
                            state_q <= WRITE;
                        end
                    end else begin
                        wait_q <= wait_q - 3'd1;
                    end
                end
`endif
                RD_ADDR: begin
                    wait_q  <= WAIT_INIT;
                    state_q <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (wait_q == 3'd0) begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= tgt_q ? dbg_data_rd2 : dbg_inst_rd2;
                        rsp_last_q  <= last_beat_s;
                        state_q     <= RSP;
                    end else begin
                        wait_q <= wait_q - 3'd1;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_data_q  <= 32'h0;
                        rsp_last_q  <= 1'b0;
`ifdef DBG_MEM_LOADER_VERIFY_EN
                        rsp_err_q   <= 1'b0;
`endif
                        if (rsp_last_q) begin
                            state_q <= IDLE;
                        end else begin
                            addr_q <= addr_d;
                            cnt_q  <= cnt_q - LEN_W'(1);
                            if (tgt_q) begin
                                data_a2_q <= addr_d;
                            end else begin
                                inst_a2_q <= addr_d;
                            end
                            state_q <= RD_ADDR;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_mem_loader.sv
// Scoreboard bench for dbg_mem_loader: directed bursts against behavioural cache models.
module tb_dbg_mem_loader;
    localparam int READ_LAT = 1;
    localparam int LEN_W    = 8;
`ifdef DBG_MEM_LOADER_VERIFY_EN
    localparam int WGAP = READ_LAT + 2;
`else
    localparam int WGAP = 1;
`endif

    logic CPU_CLK, CPU_RST;
    logic cmd_valid, cmd_ready, cmd_write, cmd_target;
    logic [31:0] cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic [3:0] cmd_be;
    logic wd_valid, wd_ready;
    logic [31:0] wd_data;
    logic rsp_valid, rsp_ready, rsp_last, rsp_err, busy;
    logic [31:0] rsp_data;
    logic [31:0] dbg_inst_a2, dbg_inst_wd2, dbg_inst_rd2;
    logic [31:0] dbg_data_a2, dbg_data_wd2, dbg_data_rd2;
    logic [3:0]  dbg_inst_we2, dbg_data_we2;

    dbg_mem_loader #(.READ_LAT(READ_LAT), .LEN_W(LEN_W)) dut (
        .CPU_CLK(CPU_CLK), .CPU_RST(CPU_RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_target(cmd_target), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_be(cmd_be),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .rsp_err(rsp_err), .busy(busy),
        .dbg_inst_a2(dbg_inst_a2), .dbg_inst_wd2(dbg_inst_wd2), .dbg_inst_we2(dbg_inst_we2),
        .dbg_inst_rd2(dbg_inst_rd2),
        .dbg_data_a2(dbg_data_a2), .dbg_data_wd2(dbg_data_wd2), .dbg_data_we2(dbg_data_we2),
        .dbg_data_rd2(dbg_data_rd2)
    );

    initial CPU_CLK = 1'b0;
    always #5 CPU_CLK = ~CPU_CLK;

    int cyc = 0;
    always @(posedge CPU_CLK) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Cache models: write-first, READ_LAT-cycle read pipeline, optional stuck bit on data reads.
    logic [31:0] imem [logic [31:0]];
    logic [31:0] dmem [logic [31:0]];
    logic [31:0] ipipe [READ_LAT];
    logic [31:0] dpipe [READ_LAT];
    logic [31:0] stuck_addr = 32'h0000_0300;
    logic [31:0] stuck_mask = 32'h0;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] we);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = we[b] ? n[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    always @(posedge CPU_CLK) begin : inst_mem
        logic [31:0] cur;
        cur = imem.exists(dbg_inst_a2) ? imem[dbg_inst_a2] : 32'h0;
        if (dbg_inst_we2 != 4'h0) begin
            cur = merge(cur, dbg_inst_wd2, dbg_inst_we2);
            imem[dbg_inst_a2] = cur;
        end
        ipipe[0] <= cur;
        for (int i = 1; i < READ_LAT; i++) ipipe[i] <= ipipe[i-1];
    end

    always @(posedge CPU_CLK) begin : data_mem
        logic [31:0] cur;
        cur = dmem.exists(dbg_data_a2) ? dmem[dbg_data_a2] : 32'h0;
        if (dbg_data_we2 != 4'h0) begin
            cur = merge(cur, dbg_data_wd2, dbg_data_we2);
            dmem[dbg_data_a2] = cur;
        end
        dpipe[0] <= cur | ((dbg_data_a2 == stuck_addr) ? stuck_mask : 32'h0);
        for (int i = 1; i < READ_LAT; i++) dpipe[i] <= dpipe[i-1];
    end

    assign dbg_inst_rd2 = ipipe[READ_LAT-1];
    assign dbg_data_rd2 = dpipe[READ_LAT-1];

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        err;
    } rsp_t;
    typedef struct packed {
        logic        tgt;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  we;
        logic        chk_gap;
    } stb_t;

    rsp_t rsp_q[$];
    stb_t stb_q[$];
    rsp_t mon_r;
    stb_t mon_s;
    logic held_v = 1'b0;
    logic [32:0] held_val;
    int last_stb_cyc = 0;

    // Response monitor: pops on each handshake and checks stability during stalls.
    always @(negedge CPU_CLK) begin
        if (CPU_RST) begin
            if (held_v && rsp_valid) check("rsp_stable", 96'({rsp_data, rsp_last}), 96'(held_val));
            held_v   = rsp_valid && !rsp_ready;
            held_val = {rsp_data, rsp_last};
            if (rsp_valid && rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: got data %h last %b, none queued", rsp_data, rsp_last);
                end else begin
                    mon_r = rsp_q.pop_front();
                    check("rsp", 96'({rsp_data, rsp_last, rsp_err}), 96'({mon_r.data, mon_r.last, mon_r.err}));
                end
            end
        end
    end

    // Strobe monitor: every nonzero we2 must match the next expected strobe.
    always @(negedge CPU_CLK) begin
        if (CPU_RST && (dbg_inst_we2 != 4'h0 || dbg_data_we2 != 4'h0)) begin
            if (stb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL strobe_unexpected: got inst_we2 %h data_we2 %h, none queued",
                         dbg_inst_we2, dbg_data_we2);
            end else begin
                mon_s = stb_q.pop_front();
                if (mon_s.tgt) begin
                    check("data_strobe", 96'({dbg_data_a2, dbg_data_wd2, dbg_data_we2}),
                          96'({mon_s.a, mon_s.d, mon_s.we}));
                    check("inst_parked", 96'({dbg_inst_a2, dbg_inst_we2}), 96'h0);
                end else begin
                    check("inst_strobe", 96'({dbg_inst_a2, dbg_inst_wd2, dbg_inst_we2}),
                          96'({mon_s.a, mon_s.d, mon_s.we}));
                    check("data_parked", 96'({dbg_data_a2, dbg_data_we2}), 96'h0);
                end
                if (mon_s.chk_gap) check("strobe_gap", 96'(cyc - last_stb_cyc), 96'(WGAP));
                last_stb_cyc = cyc;
            end
        end
    end

    logic stall_en = 1'b0;
    int   scnt = 0;
    // Response back-pressure: with stall_en each response waits three cycles before acceptance.
    always @(posedge CPU_CLK) begin
        #1;
        if (!stall_en) begin
            rsp_ready = 1'b1;
        end else if (rsp_valid && !rsp_ready) begin
            if (scnt == 3) rsp_ready = 1'b1;
            else scnt++;
        end else begin
            rsp_ready = 1'b0;
            scnt = 0;
        end
    end

    logic [31:0] wbuf [4];

    task automatic issue_cmd(input logic wr, input logic tgt, input logic [31:0] addr,
                             input logic [LEN_W-1:0] len, input logic [3:0] be);
        bit done = 1'b0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_target = tgt;
        cmd_addr = addr; cmd_len = len; cmd_be = be;
        for (int i = 0; i < 200 && !done; i++) begin
            if (cmd_ready) done = 1'b1;
            @(posedge CPU_CLK); #1;
        end
        cmd_valid = 1'b0;
        if (!done) begin
            n_chk++; n_fail++;
            $display("FAIL cmd_timeout: cmd_ready stayed 0, required 1");
        end
    endtask

    task automatic write_burst(input logic tgt, input logic [31:0] addr, input int n,
                               input logic [3:0] be, input logic err_exp, input logic poke);
        stb_t s;
        rsp_t r;
        bit got;
        for (int i = 0; i < n; i++) begin
            s.tgt = tgt;
            s.a = {addr[31:2], 2'b00} + 32'(4 * i);
            s.d = wbuf[i];
            s.we = tgt ? be : 4'hF;
            s.chk_gap = (i != 0);
            stb_q.push_back(s);
        end
        r.data = 32'h0; r.last = 1'b1; r.err = err_exp;
        rsp_q.push_back(r);
        issue_cmd(1'b1, tgt, addr, LEN_W'(n - 1), be);
        for (int i = 0; i < n; i++) begin
            wd_valid = 1'b1;
            wd_data  = wbuf[i];
            got = 1'b0;
            for (int k = 0; k < 50 && !got; k++) begin
                if (poke) begin
                    cmd_valid = 1'b1;
                    cmd_write = 1'b0;
                    check("cmd_ready_busy", 96'(cmd_ready), 96'h0);
                end
                if (wd_ready) got = 1'b1;
                @(posedge CPU_CLK); #1;
            end
            if (!got) begin
                n_chk++; n_fail++;
                $display("FAIL wd_timeout: wd_ready stayed 0, required 1");
            end
        end
        wd_valid  = 1'b0;
        cmd_valid = 1'b0;
    endtask

    task automatic read_burst(input logic tgt, input logic [31:0] addr, input int n,
                              input logic [31:0] e0, input logic [31:0] e1);
        rsp_t r;
        r.err = 1'b0;
        r.data = e0; r.last = (n == 1);
        rsp_q.push_back(r);
        if (n == 2) begin
            r.data = e1; r.last = 1'b1;
            rsp_q.push_back(r);
        end
        issue_cmd(1'b0, tgt, addr, LEN_W'(n - 1), 4'hF);
    endtask

    task automatic wait_done();
        bit done = 1'b0;
        for (int i = 0; i < 500 && !done; i++) begin
            if (rsp_q.size() == 0 && stb_q.size() == 0 && !busy) done = 1'b1;
            else begin @(posedge CPU_CLK); #1; end
        end
        if (!done) begin
            n_chk++; n_fail++;
            $display("FAIL drain_timeout: %0d responses and %0d strobes outstanding, required 0",
                     rsp_q.size(), stb_q.size());
            rsp_q.delete();
            stb_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        CPU_RST = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_target = 1'b0;
        cmd_addr = 32'h0; cmd_len = '0; cmd_be = 4'h0; wd_valid = 1'b0; wd_data = 32'h0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge CPU_CLK);
        #1;
        check("reset_ctrl", 96'({busy, rsp_valid, rsp_last, rsp_err, wd_ready, cmd_ready}), 96'b000001);
        check("reset_inst", 96'({dbg_inst_a2, dbg_inst_wd2, dbg_inst_we2}), 96'h0);
        check("reset_data", 96'({dbg_data_a2, dbg_data_wd2, dbg_data_we2}), 96'h0);
        check("reset_rspdata", 96'(rsp_data), 96'h0);
        CPU_RST = 1'b1;
        @(posedge CPU_CLK); #1;

        // Instruction program load: be ignored, unaligned start rounds down.
        wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
        write_burst(1'b0, 32'h0000_0003, 4, 4'h1, 1'b0, 1'b0);
        wait_done();
        read_burst(1'b0, 32'h0000_0008, 2, 32'h33, 32'h44);
        wait_done();

        // Data preload then stalled two-word read.
        wbuf[0] = 32'hDEAD_BEEF; wbuf[1] = 32'hCAFE_F00D;
        write_burst(1'b1, 32'h0000_0100, 2, 4'hF, 1'b0, 1'b0);
        wait_done();
        stall_en = 1'b1;
        read_burst(1'b1, 32'h0000_0100, 2, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        wait_done();
        stall_en = 1'b0;
        @(posedge CPU_CLK); #1;

        // Partial byte-enable write over an existing word.
        wbuf[0] = 32'h1122_3344;
        write_burst(1'b1, 32'h0000_0020, 1, 4'hF, 1'b0, 1'b0);
        wait_done();
        wbuf[0] = 32'hAABB_CCDD;
        write_burst(1'b1, 32'h0000_0020, 1, 4'h6, 1'b0, 1'b0);
        wait_done();
        read_burst(1'b1, 32'h0000_0020, 1, 32'h11BB_CC44, 32'h0);
        wait_done();

        // Address wrap with a command held valid while busy.
        wbuf[0] = 32'h5A5A_0001; wbuf[1] = 32'h5A5A_0002;
        write_burst(1'b1, 32'hFFFF_FFFC, 2, 4'hF, 1'b0, 1'b1);
        wait_done();
        read_burst(1'b1, 32'hFFFF_FFFC, 2, 32'h5A5A_0001, 32'h5A5A_0002);
        wait_done();

        // Reset during RD_WAIT abandons the burst silently.
        issue_cmd(1'b0, 1'b1, 32'h0000_0100, LEN_W'(0), 4'hF);
        @(posedge CPU_CLK); #1;
        CPU_RST = 1'b0;
        #1;
        check("reset_mid_read", 96'({busy, rsp_valid, wd_ready, dbg_inst_we2, dbg_data_we2}), 96'h0);
        #2;
        CPU_RST = 1'b1;
        @(posedge CPU_CLK); #1;
        read_burst(1'b1, 32'h0000_0104, 1, 32'hCAFE_F00D, 32'h0);
        wait_done();

`ifdef DBG_MEM_LOADER_VERIFY_EN
        // Stuck bit on readback flags the burst; a clean burst afterwards reports no error.
        stuck_mask = 32'h0000_0010;
        wbuf[0] = 32'h0000_0000;
        write_burst(1'b1, 32'h0000_0300, 1, 4'hF, 1'b1, 1'b0);
        wait_done();
        wbuf[0] = 32'h0000_0000;
        write_burst(1'b1, 32'h0000_0304, 1, 4'hF, 1'b0, 1'b0);
        wait_done();
`endif

        repeat (3) @(posedge CPU_CLK);
        #1;
        check("final_idle", 96'({busy, rsp_valid}), 96'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
